eeg_pipe_sequencer: RTL and testbench

Run-control sequencer for the EEG/QRS-style filter chain (L=2 upsampler, low-pass, high-pass, derivative, square, 3-tap average, M=2 downsampler). It accepts raw samples over a valid/ready handshake and drives the chain's clock-enable, clear and zero-stuff input. It suppresses outputs until the filter delay lines are primed and decimates the chain output back to the input rate. The block sits between the ADC sample source and the filter datapath; the filter taps advance only when this block asserts `pipe_ce`.

---
 rtl/eeg_pipe_sequencer.sv | 143 ++++++++++++++
 tb/tb_eeg_pipe_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeg_pipe_sequencer.sv
// Run-control for the L=2 / M=2 filter chain: clocks the taps, zero-stuffs, gates priming, decimates; build with EEG_PIPE_FLUSH_EN to drain the chain on stop.
// Latency: a primed accept at t is captured at t+1 and strobed at t+2; in_ready drops on zero-stuff cycles and whenever stop is high.
module eeg_pipe_sequencer #(
    parameter int FILL_CYCLES = 8,
    parameter int DATA_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     pipe_ce,
    output logic                     pipe_clr,
    output logic signed [DATA_W-1:0] pipe_din,
    input  logic signed [DATA_W-1:0] pipe_dout,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic [1:0]               state,
    output logic [15:0]              sample_cnt
);

    localparam int FW = $clog2(FILL_CYCLES + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(FILL_CYCLES);
    localparam logic [FW-1:0] ONE      = FW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic                       phase_q, phase_d;
    logic [FW-1:0]              fill_q, fill_d;
    logic [15:0]                cnt_q, cnt_d;
    logic                       out_valid_q;
    logic signed [DATA_W-1:0]   out_data_q;
    logic                       pipe_clr_q;
    logic                       capture;
`ifdef EEG_PIPE_FLUSH_EN
    logic [FW-1:0]              flush_q, flush_d;
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        pipe_ce  = 1'b0;
        pipe_din = '0;
`ifdef EEG_PIPE_FLUSH_EN
        flush_d  = flush_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                phase_d = 1'b0;
                fill_d  = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (phase_q) begin
                    pipe_ce = 1'b1;
                end else begin
                    in_ready = !stop;
                    if (stop) begin
`ifdef EEG_PIPE_FLUSH_EN
                        state_d = FLUSH;
                        flush_d = '0;
`else
                        state_d = IDLE;
`endif
                    end else if (in_valid) begin
                        pipe_ce  = 1'b1;
                        pipe_din = in_data;
                        cnt_d    = cnt_q + 16'd1;
                    end
                end
            end
`ifdef EEG_PIPE_FLUSH_EN
            FLUSH: begin
                pipe_ce = 1'b1;
                flush_d = flush_q + ONE;
                if (flush_q == FILL_MAX - ONE) begin
                    state_d = IDLE;
                    flush_d = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // fill_cnt is only cleared by CLEAR/reset, so a flush leaves it saturated
        if (pipe_ce) begin
            phase_d = !phase_q;
            if (fill_q != FILL_MAX) fill_d = fill_q + ONE;
        end
    end

    assign capture = pipe_ce && phase_q && (fill_q == FILL_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            fill_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            pipe_clr_q  <= 1'b0;
`ifdef EEG_PIPE_FLUSH_EN
            flush_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            out_valid_q <= capture;
            pipe_clr_q  <= (state_d == CLEAR);
            if (capture) out_data_q <= pipe_dout;
`ifdef EEG_PIPE_FLUSH_EN
            flush_q     <= flush_d;
`endif
        end
    end

    assign pipe_clr   = pipe_clr_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q != IDLE);
    assign state      = state_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_eeg_pipe_sequencer.sv
// Bench for eeg_pipe_sequencer with a one-ce delay stub standing in for the filter chain.
module tb_eeg_pipe_sequencer;

    localparam int FILL = 8;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          reset, start, stop, in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready, pipe_ce, pipe_clr, out_valid, busy;
    logic [DW-1:0] pipe_din, pipe_dout, out_data;
    logic [1:0]    state;
    logic [15:0]   sample_cnt;
    logic [DW-1:0] stub_q;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    eeg_pipe_sequencer #(.FILL_CYCLES(FILL), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .pipe_ce(pipe_ce), .pipe_clr(pipe_clr), .pipe_din(pipe_din),
        .pipe_dout(pipe_dout), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .state(state), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // chain stub: output is the previous ce-cycle's input
    always @(posedge clk) begin
        if (reset || pipe_clr) stub_q <= '0;
        else if (pipe_ce)      stub_q <= pipe_din;
    end
    assign pipe_dout = stub_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic go_idle();
        int k;
        k = 0;
        stop = 1'b1;
        in_valid = 1'b0;
        while (state !== 2'd0 && k < 40) begin
            tick();
            k++;
        end
        stop = 1'b0;
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL go_idle: state=%0d required 0", state); end
    endtask

    task automatic feed(input int n);
        int got, k;
        got = 0;
        k = 0;
        in_valid = 1'b1;
        while (got < n && k < 200) begin
            in_data = 16'($urandom());
            @(negedge clk);
            if (in_ready) got++;
            tick();
            k++;
        end
        in_valid = 1'b0;
        n_tests++; if (got != n) begin n_fail++; $display("FAIL feed: accepted %0d required %0d", got, n); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (state !== 2'd0)      begin n_fail++; $display("FAIL por_state: %0d vs 0", state); end
        n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL por_busy: %0b vs 0", busy); end
        n_tests++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL por_in_ready: %0b vs 0", in_ready); end
        n_tests++; if (pipe_clr !== 1'b0)   begin n_fail++; $display("FAIL por_pipe_clr: %0b vs 0", pipe_clr); end
        tick();
        do_start();
        feed(7);
        tick();
        in_valid = 1'b1;
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_tests++; if (state !== 2'd0)        begin n_fail++; $display("FAIL rst_state: %0d vs 0", state); end
        n_tests++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: %0b vs 0", busy); end
        n_tests++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_out_valid: %0b vs 0", out_valid); end
        n_tests++; if (out_data !== 16'd0)    begin n_fail++; $display("FAIL rst_out_data: %0h vs 0", out_data); end
        n_tests++; if (sample_cnt !== 16'd0)  begin n_fail++; $display("FAIL rst_sample_cnt: %0d vs 0", sample_cnt); end
        n_tests++; if (pipe_ce !== 1'b0)      begin n_fail++; $display("FAIL rst_pipe_ce: %0b vs 0", pipe_ce); end
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_start();
        start = 1'b1;
        @(negedge clk);
        n_tests++; if (pipe_clr !== 1'b0) begin n_fail++; $display("FAIL start_clr_c0: %0b vs 0", pipe_clr); end
        tick();
        start = 1'b0;
        @(negedge clk);
        n_tests++; if (pipe_clr !== 1'b1) begin n_fail++; $display("FAIL start_clr_c1: %0b vs 1", pipe_clr); end
        n_tests++; if (state !== 2'd1)    begin n_fail++; $display("FAIL start_state_c1: %0d vs 1", state); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL start_ready_c1: %0b vs 0", in_ready); end
        tick();
        @(negedge clk);
        n_tests++; if (pipe_clr !== 1'b0) begin n_fail++; $display("FAIL start_clr_c2: %0b vs 0", pipe_clr); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready_c2: %0b vs 1", in_ready); end
        n_tests++; if (state !== 2'd2)    begin n_fail++; $display("FAIL start_state_c2: %0d vs 2", state); end
        tick();
        go_idle();
    endtask

    task automatic test_priming();
        int acc_cyc[6];
        logic [DW-1:0] samp[6];
        int ov_cyc[$];
        logic [DW-1:0] ov_dat[$];
        int k, n;
        for (int i = 0; i < 6; i++) samp[i] = 16'(i * 16'h1111 + 16'h0101);
        do_start();
        n = 0;
        k = 0;
        while (k < 60 && !(n == 6 && cyc > acc_cyc[5] + 3)) begin
            in_valid = (n < 6);
            in_data  = (n < 6) ? samp[n] : 16'd0;
            @(negedge clk);
            if (out_valid) begin ov_cyc.push_back(cyc); ov_dat.push_back(out_data); end
            if (in_valid && in_ready) begin acc_cyc[n] = cyc; n++; end
            tick();
            k++;
        end
        in_valid = 1'b0;
        n_tests++; if (n != 6) begin n_fail++; $display("FAIL prime_accepts: %0d vs 6", n); end
        n_tests++; if (sample_cnt !== 16'd6) begin n_fail++; $display("FAIL prime_sample_cnt: %0d vs 6", sample_cnt); end
        n_tests++; if (acc_cyc[1] != acc_cyc[0] + 2) begin n_fail++; $display("FAIL prime_throughput: gap %0d vs 2", acc_cyc[1] - acc_cyc[0]); end
        n_tests++; if (ov_cyc.size() != 2) begin n_fail++; $display("FAIL prime_strobes: %0d vs 2", ov_cyc.size()); end
        if (ov_cyc.size() >= 2) begin
            n_tests++; if (ov_cyc[0] != acc_cyc[4] + 2) begin n_fail++; $display("FAIL prime_first_time: cyc %0d vs %0d", ov_cyc[0], acc_cyc[4] + 2); end
            n_tests++; if (ov_dat[0] !== samp[4]) begin n_fail++; $display("FAIL prime_first_data: %0h vs %0h", ov_dat[0], samp[4]); end
            n_tests++; if (ov_cyc[1] != acc_cyc[5] + 2) begin n_fail++; $display("FAIL prime_second_time: cyc %0d vs %0d", ov_cyc[1], acc_cyc[5] + 2); end
            n_tests++; if (ov_dat[1] !== samp[5]) begin n_fail++; $display("FAIL prime_second_data: %0h vs %0h", ov_dat[1], samp[5]); end
        end
        go_idle();
    endtask

    task automatic test_stall();
        logic [15:0] sc;
        logic [DW-1:0] d;
        do_start();
        feed(2);
        tick();
        sc = sample_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if (pipe_ce !== 1'b0)  begin n_fail++; $display("FAIL stall_ce[%0d]: %0b vs 0", i, pipe_ce); end
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready[%0d]: %0b vs 1", i, in_ready); end
            n_tests++; if (sample_cnt !== sc) begin n_fail++; $display("FAIL stall_cnt[%0d]: %0d vs %0d", i, sample_cnt, sc); end
            tick();
        end
        d = 16'($urandom());
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        n_tests++; if (pipe_ce !== 1'b1) begin n_fail++; $display("FAIL stall_resume_ce: %0b vs 1", pipe_ce); end
        n_tests++; if (pipe_din !== d)   begin n_fail++; $display("FAIL stall_resume_din: %0h vs %0h", pipe_din, d); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (sample_cnt !== sc + 16'd1) begin n_fail++; $display("FAIL stall_resume_cnt: %0d vs %0d", sample_cnt, sc + 16'd1); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_stuff_ready: %0b vs 0", in_ready); end
        tick();
        go_idle();
    endtask

    task automatic test_stop();
        logic [15:0] sc;
        int ov;
        do_start();
        feed(6);
        stop = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        n_tests++; if (pipe_ce !== 1'b1) begin n_fail++; $display("FAIL stop_ph1_ce: %0b vs 1", pipe_ce); end
        n_tests++; if (state !== 2'd2)   begin n_fail++; $display("FAIL stop_ph1_state: %0d vs 2", state); end
        tick();
        @(negedge clk);
        sc = sample_cnt;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stop_ready: %0b vs 0", in_ready); end
        n_tests++; if (pipe_ce !== 1'b0)  begin n_fail++; $display("FAIL stop_ce: %0b vs 0", pipe_ce); end
        tick();
`ifdef EEG_PIPE_FLUSH_EN
        ov = 0;
        for (int i = 0; i < FILL; i++) begin
            @(negedge clk);
            n_tests++; if (state !== 2'd3)    begin n_fail++; $display("FAIL flush_state[%0d]: %0d vs 3", i, state); end
            n_tests++; if (pipe_ce !== 1'b1)  begin n_fail++; $display("FAIL flush_ce[%0d]: %0b vs 1", i, pipe_ce); end
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready[%0d]: %0b vs 0", i, in_ready); end
            n_tests++; if (pipe_din !== 16'd0) begin n_fail++; $display("FAIL flush_din[%0d]: %0h vs 0", i, pipe_din); end
            if (out_valid) ov++;
            tick();
            stop = 1'b0;
        end
        @(negedge clk);
        if (out_valid) ov++;
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL flush_exit: %0d vs 0", state); end
        n_tests++; if (ov != FILL / 2) begin n_fail++; $display("FAIL flush_strobes: %0d vs %0d", ov, FILL / 2); end
`else
        ov = 0;
        @(negedge clk);
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL stop_exit: %0d vs 0", state); end
        n_tests++; if (pipe_ce !== 1'b0) begin n_fail++; $display("FAIL stop_idle_ce: %0b vs 0", pipe_ce); end
        n_tests++; if (ov != 0) begin n_fail++; $display("FAIL stop_strobes: %0d vs 0", ov); end
`endif
        n_tests++; if (sample_cnt !== sc) begin n_fail++; $display("FAIL stop_cnt: %0d vs %0d", sample_cnt, sc); end
        stop = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

`ifdef EEG_PIPE_FLUSH_EN
    task automatic test_reset_flush();
        do_start();
        feed(6);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        n_tests++; if (state !== 2'd3) begin n_fail++; $display("FAIL rflush_pre: %0d vs 3", state); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if (state !== 2'd0)     begin n_fail++; $display("FAIL rflush_state[%0d]: %0d vs 0", i, state); end
            n_tests++; if (pipe_ce !== 1'b0)   begin n_fail++; $display("FAIL rflush_ce[%0d]: %0b vs 0", i, pipe_ce); end
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rflush_ov[%0d]: %0b vs 0", i, out_valid); end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        n_tests++; if (pipe_clr !== 1'b1) begin n_fail++; $display("FAIL rflush_clr: %0b vs 1", pipe_clr); end
        n_tests++; if (state !== 2'd1)    begin n_fail++; $display("FAIL rflush_clear: %0d vs 1", state); end
        tick();
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rflush_ready: %0b vs 1", in_ready); end
        tick();
        go_idle();
    endtask
`endif

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } exp_t;

    // Reference: after each accept the next cycle is a zero-stuff; accepts beyond the first FILL/2 emerge two cycles later
    task automatic test_random();
        exp_t q[$];
        int n, last_acc, pct;
        logic exp_ready, exp_ce, exp_ov, acc;
        for (int run = 0; run < 4; run++) begin
            pct = 30 + run * 20;
            do_start();
            q.delete();
            n = 0;
            last_acc = -10;
            for (int c = 0; c < 150; c++) begin
                in_valid = ($urandom_range(0, 99) < pct);
                in_data  = 16'($urandom());
                @(negedge clk);
                exp_ready = (cyc != last_acc + 1);
                acc       = in_valid && exp_ready;
                exp_ce    = acc || (cyc == last_acc + 1);
                exp_ov    = (q.size() > 0) && (q[0].due == cyc);
                n_tests++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: %0b vs %0b", cyc, in_ready, exp_ready); end
                n_tests++; if (pipe_ce !== exp_ce)     begin n_fail++; $display("FAIL rnd_ce c%0d: %0b vs %0b", cyc, pipe_ce, exp_ce); end
                n_tests++; if (sample_cnt !== 16'(n))  begin n_fail++; $display("FAIL rnd_cnt c%0d: %0d vs %0d", cyc, sample_cnt, n); end
                n_tests++; if (out_valid !== exp_ov)   begin n_fail++; $display("FAIL rnd_ov c%0d: %0b vs %0b", cyc, out_valid, exp_ov); end
                if (acc) begin
                    n_tests++; if (pipe_din !== in_data) begin n_fail++; $display("FAIL rnd_din c%0d: %0h vs %0h", cyc, pipe_din, in_data); end
                end else if (exp_ce) begin
                    n_tests++; if (pipe_din !== 16'd0) begin n_fail++; $display("FAIL rnd_stuff c%0d: %0h vs 0", cyc, pipe_din); end
                end
                if (exp_ov) begin
                    n_tests++; if (out_data !== q[0].d) begin n_fail++; $display("FAIL rnd_data c%0d: %0h vs %0h", cyc, out_data, q[0].d); end
                    void'(q.pop_front());
                end
                if (acc) begin
                    n++;
                    last_acc = cyc;
                    if (n > FILL / 2) q.push_back('{due: cyc + 2, d: in_data});
                end
                tick();
            end
            go_idle();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_start();
        test_priming();
        test_stall();
        test_stop();
`ifdef EEG_PIPE_FLUSH_EN
        test_reset_flush();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
